// File: rtl/regfile_dual.sv
// Dual architectural register file: 32 integer GPRs plus 32 FP registers.
// Combinational reads with same-cycle writeback bypass and FP pair reads.
module regfile_dual (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwr,
  input  logic [4:0]  rw,
  input  logic [31:0] busW,
  input  logic [1:0]  fpoint,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] busA,
  output logic [31:0] busB,
  input  logic [4:0]  fa,
  input  logic [4:0]  fb,
  output logic [31:0] fbusA,
  output logic [31:0] fbusB,
  output logic [63:0] dbusA,
  output logic [63:0] dbusB
);

  logic [31:0] r [32];
  logic [31:0] f [32];
  logic [4:0]  fw;
  logic        int_we;
  logic        fp_we;

  // Double halves force the pair slot regardless of rw[0].
  always_comb begin
    fw = rw;
    unique case (fpoint)
      2'b10:   fw = {rw[4:1], 1'b0};
      2'b11:   fw = {rw[4:1], 1'b1};
      default: fw = rw;
    endcase
  end

  assign int_we = regwr & ~reset
                & (fpoint == 2'b00)
                & (rw != 5'd0);
  assign fp_we  = regwr & ~reset
                & (fpoint != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r[i] <= '0;
        f[i] <= '0;
      end
    end else begin
      if (int_we) r[rw] <= busW;
      if (fp_we)  f[fw] <= busW;
    end
  end

  function automatic logic [31:0] rd_int(
    input logic [4:0] idx
  );
    if (reset || idx == 5'd0) return '0;
    if (int_we && idx == rw) return busW;
    return r[idx];
  endfunction

  function automatic logic [31:0] rd_fp(
    input logic [4:0] idx
  );
    if (reset) return '0;
    if (fp_we && idx == fw) return busW;
    return f[idx];
  endfunction

  always_comb begin
    busA  = rd_int(ra);
    busB  = rd_int(rb);
    fbusA = rd_fp(fa);
    fbusB = rd_fp(fb);
    dbusA = {rd_fp({fa[4:1], 1'b1}),
             rd_fp({fa[4:1], 1'b0})};
    dbusB = {rd_fp({fb[4:1], 1'b1}),
             rd_fp({fb[4:1], 1'b0})};
  end

endmodule
